// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM states, MIPS field
// bit positions and the default reset PC.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,  // no request outstanding
    ST_REQ  = 2'b01,  // live request outstanding
    ST_DROP = 2'b10   // stale request outstanding, response discarded
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // MIPS instruction field positions
  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int SHAMT_HI = 10;
  localparam int SHAMT_LO = 6;
  localparam int FUNC_HI  = 5;
  localparam int FUNC_LO  = 0;
  localparam int IMME_HI  = 15;
  localparam int IMME_LO  = 0;

  // Next sequential word address; wraps modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Force a target onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch queue of {pc, instr} pairs with a flush that
// overrides any same-cycle push or pop.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [31:0]   push_pc,
  input  logic [31:0]   push_instr,
  input  logic          pop,
  output logic          empty,
  output logic [AW:0]   count,
  output logic [31:0]   head_pc,
  output logic [31:0]   head_instr
);

  logic [63:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;

  assign empty      = (count_r == '0);
  assign count      = count_r;
  assign head_pc    = mem_r[rd_ptr_r][63:32];
  assign head_instr = mem_r[rd_ptr_r][31:0];

  // Pointer and occupancy tracking; flush empties the queue outright.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + (AW+1)'(1'b1);
        2'b01:   count_r <= count_r - (AW+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; cleared on reset so the head never shows stale data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 64'd0;
      end
    end else if (push && !flush) begin
      mem_r[wr_ptr_r] <= {push_pc, push_instr};
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: single-outstanding memory request FSM,
// redirect handling and MIPS field decode of the prefetch-queue head.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc4,
  output logic [5:0]  op,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  func,
  output logic [15:0] imme
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  fetch_state_e state_r, state_nx_s;
  logic [31:0]  fetch_pc_r, fetch_pc_nx_s;
  logic         mem_req_r, mem_req_nx_s;
  logic [31:0]  mem_addr_r, mem_addr_nx_s;

  logic         push_s;
  logic         pop_s;
  logic         empty_s;
  logic [AW:0]  count_s;
  logic [AW:0]  post_cnt_s;
  logic [31:0]  head_pc_s;
  logic [31:0]  head_instr_s;
  logic [31:0]  redir_tgt_s;

  // A live response is queued only when no redirect kills it this cycle;
  // a redirect flush likewise cancels any same-cycle pop.
  assign push_s      = (state_r == ST_REQ) && mem_ack && !redir_valid;
  assign pop_s       = out_valid && out_ready && !redir_valid;
  assign post_cnt_s  = count_s + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
  assign redir_tgt_s = word_align(redir_pc);

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redir_valid),
    .push       (push_s),
    .push_pc    (mem_addr_r),
    .push_instr (mem_rdata),
    .pop        (pop_s),
    .empty      (empty_s),
    .count      (count_s),
    .head_pc    (head_pc_s),
    .head_instr (head_instr_s)
  );

  // Next-state, next fetch PC and next request outputs.
  always_comb begin
    state_nx_s    = state_r;
    fetch_pc_nx_s = fetch_pc_r;
    mem_req_nx_s  = mem_req_r;
    mem_addr_nx_s = mem_addr_r;
    case (state_r)
      ST_IDLE: begin
        if (redir_valid) begin
          fetch_pc_nx_s = redir_tgt_s;
          state_nx_s    = ST_IDLE;
          mem_req_nx_s  = 1'b0;
        end else if (count_s < DEPTH_CNT) begin
          state_nx_s    = ST_REQ;
          mem_req_nx_s  = 1'b1;
          mem_addr_nx_s = fetch_pc_r;
        end else begin
          state_nx_s    = ST_IDLE;
          mem_req_nx_s  = 1'b0;
        end
      end
      ST_REQ: begin
        if (redir_valid) begin
          fetch_pc_nx_s = redir_tgt_s;
          if (mem_ack) begin
            state_nx_s   = ST_IDLE;
            mem_req_nx_s = 1'b0;
          end else begin
            state_nx_s   = ST_DROP;
          end
        end else if (mem_ack) begin
          fetch_pc_nx_s = pc_plus4(mem_addr_r);
          if (post_cnt_s < DEPTH_CNT) begin
            state_nx_s    = ST_REQ;
            mem_addr_nx_s = pc_plus4(mem_addr_r);
          end else begin
            state_nx_s    = ST_IDLE;
            mem_req_nx_s  = 1'b0;
          end
        end else begin
          state_nx_s = ST_REQ;
        end
      end
      ST_DROP: begin
        if (redir_valid) begin
          fetch_pc_nx_s = redir_tgt_s;
        end else begin
          fetch_pc_nx_s = fetch_pc_r;
        end
        if (mem_ack) begin
          state_nx_s   = ST_IDLE;
          mem_req_nx_s = 1'b0;
        end else begin
          state_nx_s   = ST_DROP;
        end
      end
      default: begin
        state_nx_s   = ST_IDLE;
        mem_req_nx_s = 1'b0;
      end
    endcase
  end

  // State, fetch PC and registered memory request outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      fetch_pc_r <= RESET_PC;
      mem_req_r  <= 1'b0;
      mem_addr_r <= 32'd0;
    end else begin
      state_r    <= state_nx_s;
      fetch_pc_r <= fetch_pc_nx_s;
      mem_req_r  <= mem_req_nx_s;
      mem_addr_r <= mem_addr_nx_s;
    end
  end

  assign mem_req   = mem_req_r;
  assign mem_addr  = mem_addr_r;
  assign out_valid = !empty_s;

  // Head outputs are forced to zero whenever the queue is empty.
  assign out_pc  = out_valid ? head_pc_s             : 32'd0;
  assign out_pc4 = out_valid ? pc_plus4(head_pc_s)   : 32'd0;
  assign op      = out_valid ? head_instr_s[OP_HI:OP_LO]       : 6'd0;
  assign rs      = out_valid ? head_instr_s[RS_HI:RS_LO]       : 5'd0;
  assign rt      = out_valid ? head_instr_s[RT_HI:RT_LO]       : 5'd0;
  assign rd      = out_valid ? head_instr_s[RD_HI:RD_LO]       : 5'd0;
  assign shamt   = out_valid ? head_instr_s[SHAMT_HI:SHAMT_LO] : 5'd0;
  assign func    = out_valid ? head_instr_s[FUNC_HI:FUNC_LO]   : 6'd0;
  assign imme    = out_valid ? head_instr_s[IMME_HI:IMME_LO]   : 16'd0;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4: prefetch queue entries; SHALL be a power of 2 and at least 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 clk  in  1  single clock; all state SHALL update on posedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-low: rst=0 resets immediately, independent of clk.
REQ-005 mem_req  out  1  instruction read request; SHALL be a registered output.
REQ-006 mem_addr  out  32  word address of the request; SHALL be a registered output.
REQ-007 mem_ack  in  1  one-cycle pulse: mem_rdata is valid for the outstanding request.
REQ-008 mem_rdata  in  32  instruction word.
REQ-009 redir_valid  in  1  branch/jump redirect strobe.
REQ-010 redir_pc  in  32  redirect target.
REQ-011 out_valid  out  1  head instruction available to decode.
REQ-012 out_ready  in  1  decode accepts the head.
REQ-013 out_pc, out_pc4  out  32 each  head instruction address and that address +4.
REQ-014 op[5:0], rs[4:0], rt[4:0], rd[4:0], shamt[4:0], func[5:0], imme[15:0]  out: MIPS fields of the head word, bits [31:26], [25:21], [20:16], [15:11], [10:6], [5:0], [15:0].

Function
REQ-015 Fetch FSM states: IDLE (no request outstanding), REQ (live request outstanding), DROP (stale request outstanding, response discarded).
REQ-016 IDLE -> REQ on the next edge when the queue holds fewer than DEPTH entries; at that edge mem_addr takes fetch_pc and mem_req goes to 1.
REQ-017 In REQ and DROP, mem_req and mem_addr SHALL hold stable until the mem_ack cycle; at most one request is outstanding.
REQ-018 REQ on mem_ack without redirect: push {mem_addr, mem_rdata}; fetch_pc += 4; stay in REQ with mem_addr = mem_addr+4 when the post-edge entry count is below DEPTH, else go to IDLE with mem_req=0.
REQ-019 Post-edge count SHALL account for a same-cycle pop; push and pop in one cycle leave the count unchanged.
REQ-020 Queued entries plus the live in-flight request SHALL never exceed DEPTH; overflow is impossible by construction.
REQ-021 out_valid = queue non-empty; a pop occurs on out_valid and out_ready; entry-to-output latency is 1 cycle after mem_ack.
REQ-022 When out_valid=0, out_pc, out_pc4 and all field outputs SHALL be 0.
REQ-023 On redir_valid: flush the queue (out_valid=0 next cycle) and set fetch_pc=redir_pc; from IDLE go to IDLE; from REQ without ack go to DROP; from DROP stay in DROP.
REQ-024 Redirect in the same cycle as mem_ack: the response is discarded and the FSM goes to IDLE.
REQ-025 Redirect in the same cycle as a pop: the flush wins and the pop has no further effect.
REQ-026 DROP on mem_ack: discard the data, go to IDLE (mem_req=0); the next request issues from the latest fetch_pc per REQ-016.
REQ-027 redir_pc[1:0] is ignored; addresses are word-aligned; PC arithmetic wraps modulo 2^32.
REQ-028 The queue is circular: read/write pointers are log2(DEPTH) bits and wrap; count is log2(DEPTH)+1 bits.

Reset
REQ-029 While rst=0: state IDLE, fetch_pc=RESET_PC, mem_req=0, mem_addr=0, queue empty, out_valid=0, all field outputs 0.
REQ-030 Reset mid-request: the outstanding request is abandoned; a mem_ack after reset release with no request issued SHALL be ignored.

Structure
REQ-031 Shared package cpu_pkg: FSM state enum, MIPS field bit-position constants, and the default reset PC.
REQ-032 One sub-module, fetch_fifo (DEPTH x 64-bit {pc, instr} circular FIFO with flush); field slicing, FSM and PC logic stay in fetch_unit.

Verification
REQ-033 Reset release, mem_ack 1 cycle after each request, out_ready=1 -> mem_addr sequence 0,4,8,C; out_pc matches; word 0x012A4020 yields op=0, rs=9, rt=10, rd=8, shamt=0, func=0x20.
REQ-034 out_ready=0, DEPTH=4, immediate acks -> exactly 4 pushes, then mem_req=0; raising out_ready resumes fetch at 0x10.
REQ-035 Redirect to 0x100 while a request to 0x8 is pending -> DROP; the 0x8 ack is discarded; next mem_addr=0x100; no 0x8 entry appears at the output.
REQ-036 redir_valid coincident with mem_ack and a pop -> queue empty next cycle, FSM IDLE, next request to redir_pc.
REQ-037 fetch_pc=0xFFFFFFFC, ack -> next mem_addr=0x00000000; out_pc4=0x00000000.
REQ-038 rst=0 asserted mid-REQ between edges -> mem_req and out_valid drop immediately; after release the first request is to RESET_PC.
